// File: rtl/nios2_pio_edge_irq.sv
// nios2_pio_edge_irq
// Avalon-MM slave PIO with an output register (direct load, atomic set and
// atomic clear), a synchronised input port, per-bit edge capture with
// write-1-to-clear and a maskable level interrupt.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous active-high reset
//   address     word offset of the register being accessed
//   chipselect  slave select
//   write_n     active-low write strobe (write = chipselect & ~write_n)
//   writedata   write data, bits above DATA_WIDTH ignored
//   readdata    zero-wait-state read data, bits above DATA_WIDTH are 0
//   in_port     asynchronous external inputs
//   out_port    registered output
//   irq         active-high level interrupt
module nios2_pio_edge_irq #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    EDGE_TYPE   = 0,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    typedef enum logic [2:0] {
        ADDR_OUT      = 3'd0,
        ADDR_IN       = 3'd1,
        ADDR_IRQ_MASK = 3'd2,
        ADDR_EDGE_CAP = 3'd3,
        ADDR_OUTSET   = 3'd4,
        ADDR_OUTCLR   = 3'd5
    } reg_addr_e;

    localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [DATA_WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] in_prev_q, in_prev_d;
    logic [WARM_W-1:0]     warm_q, warm_d;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] in_sync;
    logic [DATA_WIDTH-1:0] edge_term;
    logic [DATA_WIDTH-1:0] clr_bits;
    logic [DATA_WIDTH-1:0] rd_field;

    assign wr_en   = chipselect & ~write_n;
    assign wd      = writedata[DATA_WIDTH-1:0];
    assign in_sync = sync_q[SYNC_STAGES-1];

    // The upper write-data bits have no destination when the port is narrow.
    if (DATA_WIDTH < 32) begin : g_unused_hi
        logic unused_wd_hi;
        assign unused_wd_hi = ^writedata[31:DATA_WIDTH];
    end

    // Bus writes, synchroniser shifting, edge detection and the warm-up
    // count. A clear and a new edge on the same bit resolve to set, so an
    // edge arriving while software acknowledges the previous one is not lost.
    always_comb begin
        out_d      = out_q;
        irq_mask_d = irq_mask_q;
        clr_bits   = '0;
        if (wr_en) begin
            case (address)
                ADDR_OUT:      out_d      = wd;
                ADDR_IRQ_MASK: irq_mask_d = wd;
                ADDR_EDGE_CAP: clr_bits   = wd;
                ADDR_OUTSET:   out_d      = out_q | wd;
                ADDR_OUTCLR:   out_d      = out_q & ~wd;
                default:       ;
            endcase
        end

        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        in_prev_d = in_sync;

        case (EDGE_TYPE)
            1:       edge_term = ~in_sync & in_prev_q;
            2:       edge_term = in_sync ^ in_prev_q;
            default: edge_term = in_sync & ~in_prev_q;
        endcase

        // Captures stay off until the synchroniser and history flop hold
        // real samples; otherwise a high input at reset looks like an edge.
        edge_cap_d = edge_cap_q & ~clr_bits;
        if (warm_q == '0) begin
            edge_cap_d = edge_cap_d | edge_term;
        end

        warm_d = (warm_q == '0) ? '0 : warm_q - WARM_W'(1);
    end

    // Register update; reset overrides any write sampled on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= RESET_VALUE;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            in_prev_q  <= '0;
            warm_q     <= WARM_LOAD;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            out_q      <= out_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            in_prev_q  <= in_prev_d;
            warm_q     <= warm_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    // Zero-wait-state read mux; it ignores chipselect and has no side effects.
    always_comb begin
        case (address)
            ADDR_OUT:      rd_field = out_q;
            ADDR_IN:       rd_field = in_sync;
            ADDR_IRQ_MASK: rd_field = irq_mask_q;
            ADDR_EDGE_CAP: rd_field = edge_cap_q;
            default:       rd_field = '0;
        endcase
        readdata                 = '0;
        readdata[DATA_WIDTH-1:0] = rd_field;
    end

    assign out_port = out_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_nios2_pio_edge_irq.sv
// Testbench for nios2_pio_edge_irq. Two instances share one bus: an 8-bit
// rising-edge PIO with two synchroniser stages, and a 1-bit any-edge PIO
// with three stages. A reference model keeps every input sample since reset
// and derives the expected registers from sample indices; a monitor pops the
// expected view each cycle and compares outputs and read data.
module tb_nios2_pio_edge_irq;

    localparam int         W0  = 8;
    localparam int         ET0 = 0;
    localparam int         S0  = 2;
    localparam logic [7:0] RV0 = 8'h3C;
    localparam int         W1  = 1;
    localparam int         ET1 = 2;
    localparam int         S1  = 3;
    localparam logic [0:0] RV1 = 1'b1;
    localparam int         HIST = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [7:0]  in0 = 8'd0;
    logic [0:0]  in1 = 1'b0;
    logic [31:0] rd0, rd1;
    logic [7:0]  out0;
    logic [0:0]  out1;
    logic        irq0, irq1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] out0;
        logic        irq0;
        logic [31:0] rd0;
        logic [31:0] out1;
        logic        irq1;
        logic [31:0] rd1;
    } exp_t;

    exp_t sbq[$];

    // Reference model state, index 0 = first DUT, 1 = second DUT
    logic [31:0] mOut[2];
    logic [31:0] mMask[2];
    logic [31:0] mCap[2];
    int          mCount[2];
    logic [31:0] samp[2][HIST];
    logic        modelValid = 1'b0;

    nios2_pio_edge_irq #(
        .DATA_WIDTH(W0), .RESET_VALUE(RV0), .EDGE_TYPE(ET0), .SYNC_STAGES(S0)
    ) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in0), .out_port(out0), .irq(irq0)
    );

    nios2_pio_edge_irq #(
        .DATA_WIDTH(W1), .RESET_VALUE(RV1), .EDGE_TYPE(ET1), .SYNC_STAGES(S1)
    ) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in1), .out_port(out1), .irq(irq1)
    );

    always #5 clk = ~clk;

    function automatic int widthOf(int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic int stagesOf(int d);
        return (d == 0) ? S0 : S1;
    endfunction

    function automatic int edgeTypeOf(int d);
        return (d == 0) ? ET0 : ET1;
    endfunction

    function automatic logic [31:0] resetOf(int d);
        return (d == 0) ? 32'(RV0) : 32'(RV1);
    endfunction

    function automatic logic [31:0] wmaskOf(int d);
        logic [63:0] one;
        one = 64'd1;
        return 32'((one << widthOf(d)) - 64'd1);
    endfunction

    // Input value sampled on the k-th clock edge after reset (0 before that)
    function automatic logic [31:0] sampleAt(int d, int k);
        if (k < 1 || k > mCount[d] || k >= HIST) return 32'd0;
        return samp[d][k];
    endfunction

    function automatic logic [31:0] modelRead(int d, logic [2:0] addr);
        case (addr)
            3'd0:    return mOut[d];
            3'd1:    return sampleAt(d, mCount[d] - stagesOf(d) + 1);
            3'd2:    return mMask[d];
            3'd3:    return mCap[d];
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock edge with the given bus/input values.
    // The input seen by the edge detector at edge n is sample n-S, compared
    // against sample n-S-1; captures are allowed from edge S+2 onwards.
    task automatic modelEdge(input int d, input logic rst, input logic wr,
                             input logic [2:0] addr, input logic [31:0] wdIn,
                             input logic [31:0] inVal);
        logic [31:0] wm, wdm, cur, prev, ev, clr, newOut;
        int n, s;
        wm = wmaskOf(d);
        s  = stagesOf(d);
        if (rst) begin
            mOut[d]   = resetOf(d);
            mMask[d]  = 32'd0;
            mCap[d]   = 32'd0;
            mCount[d] = 0;
            return;
        end
        wdm = wdIn & wm;
        n = mCount[d] + 1;
        mCount[d] = n;
        if (n < HIST) samp[d][n] = inVal & wm;
        cur  = sampleAt(d, n - s);
        prev = sampleAt(d, n - s - 1);
        case (edgeTypeOf(d))
            1:       ev = ~cur & prev;
            2:       ev = cur ^ prev;
            default: ev = cur & ~prev;
        endcase
        if (n < s + 2) ev = 32'd0;
        clr = 32'd0;
        newOut = mOut[d];
        if (wr) begin
            case (addr)
                3'd0:    newOut = wdm;
                3'd2:    mMask[d] = wdm;
                3'd3:    clr = wdm;
                3'd4:    newOut = mOut[d] | wdm;
                3'd5:    newOut = mOut[d] & ~wdm;
                default: ;
            endcase
        end
        mCap[d] = ((mCap[d] & ~clr) | ev) & wm;
        mOut[d] = newOut & wm;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Publishes the expected view of the current cycle, drives the next
    // stimulus, advances the model and returns just after the clock edge.
    task automatic applyStimulus(input logic rst, input logic cs, input logic wn,
                                 input logic [2:0] addr, input logic [31:0] wd,
                                 input logic [7:0] i0, input logic [0:0] i1);
        exp_t e;
        if (modelValid) begin
            e.out0 = mOut[0];
            e.irq0 = |(mCap[0] & mMask[0]);
            e.rd0  = modelRead(0, addr);
            e.out1 = mOut[1];
            e.irq1 = |(mCap[1] & mMask[1]);
            e.rd1  = modelRead(1, addr);
            sbq.push_back(e);
        end
        reset      = rst;
        chipselect = cs;
        write_n    = wn;
        address    = addr;
        writedata  = wd;
        in0        = i0;
        in1        = i1;
        modelEdge(0, rst, cs && !wn, addr, wd, 32'(i0));
        modelEdge(1, rst, cs && !wn, addr, wd, 32'(i1));
        if (rst) modelValid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [2:0] addr);
        applyStimulus(1'b0, 1'b0, 1'b1, addr, 32'd0, in0, in1);
    endtask

    task automatic busWrite(input logic [2:0] addr, input logic [31:0] wd);
        applyStimulus(1'b0, 1'b1, 1'b0, addr, wd, in0, in1);
    endtask

    task automatic setInputs(input logic [7:0] i0, input logic [0:0] i1,
                             input logic [2:0] addr);
        applyStimulus(1'b0, 1'b0, 1'b1, addr, 32'd0, i0, i1);
    endtask

    // Monitor: compares the DUT against the expected view mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput("sb_out0", 32'(out0), e.out0);
                checkOutput("sb_irq0", 32'(irq0), 32'(e.irq0));
                checkOutput("sb_rd0",  rd0,       e.rd0);
                checkOutput("sb_out1", 32'(out1), e.out1);
                checkOutput("sb_irq1", 32'(irq1), 32'(e.irq1));
                checkOutput("sb_rd1",  rd1,       e.rd1);
            end
        end
    end

    initial begin
        logic [7:0] nextIn0;
        logic [0:0] nextIn1;
        bit drained;
        @(posedge clk);
        #1;

        // Reset held with all inputs high, then released: no false captures
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b1, 3'd3, 32'd0, 8'hFF, 1'b1);
        checkOutput("reset_out0", 32'(out0), 32'h3C);
        checkOutput("reset_out1", 32'(out1), 32'h1);
        checkOutput("reset_irq0", 32'(irq0), 32'h0);
        repeat (10) idle(3'd3);
        checkOutput("warm_edgecap0", rd0, 32'h0);
        checkOutput("warm_edgecap1", rd1, 32'h0);
        checkOutput("warm_irq0", 32'(irq0), 32'h0);
        idle(3'd1);
        checkOutput("in_read0", rd0, 32'h000000FF);

        // Output register: load, atomic set, atomic clear
        busWrite(3'd0, 32'hA5);
        checkOutput("out_load", 32'(out0), 32'hA5);
        busWrite(3'd4, 32'h0F);
        checkOutput("out_set", 32'(out0), 32'hAF);
        busWrite(3'd5, 32'h81);
        checkOutput("out_clr", 32'(out0), 32'h2E);
        checkOutput("outclr_read", rd0, 32'h0);
        idle(3'd4);
        checkOutput("outset_read", rd0, 32'h0);
        idle(3'd0);
        checkOutput("out_read", rd0, 32'h0000002E);

        // Rising edge on bit 0 with bit 0 unmasked, then acknowledge it
        repeat (4) setInputs(8'h00, 1'b1, 3'd3);
        busWrite(3'd2, 32'h01);
        setInputs(8'h01, 1'b1, 3'd3);
        idle(3'd3);
        checkOutput("irq_before_latency", 32'(irq0), 32'h0);
        idle(3'd3);
        checkOutput("irq_after_latency", 32'(irq0), 32'h1);
        checkOutput("edgecap_bit0", rd0, 32'h01);
        busWrite(3'd3, 32'h01);
        checkOutput("irq_after_clear", 32'(irq0), 32'h0);
        checkOutput("edgecap_after_clear", rd0, 32'h0);

        // Clear of bit 3 lands on the same edge as a fresh capture of bit 3
        setInputs(8'h09, 1'b1, 3'd3);
        idle(3'd3);
        idle(3'd3);
        checkOutput("edgecap_bit3", rd0, 32'h08);
        setInputs(8'h01, 1'b1, 3'd3);
        setInputs(8'h09, 1'b1, 3'd3);
        idle(3'd3);
        busWrite(3'd3, 32'h08);
        checkOutput("clear_vs_set", rd0, 32'h08);
        busWrite(3'd3, 32'h08);
        checkOutput("clear_plain", rd0, 32'h0);

        // Any-edge instance: falling edge captured while masked, then unmask
        busWrite(3'd2, 32'h00);
        setInputs(in0, 1'b0, 3'd3);
        repeat (3) idle(3'd3);
        checkOutput("any_edge_cap1", rd1, 32'h1);
        checkOutput("any_edge_irq_masked", 32'(irq1), 32'h0);
        busWrite(3'd2, 32'h01);
        checkOutput("any_edge_irq_unmasked", 32'(irq1), 32'h1);

        // Reset mid-pending overrides a same-cycle write
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'hFFFFFFFF, in0, in1);
        checkOutput("midreset_out0", 32'(out0), 32'h3C);
        checkOutput("midreset_out1", 32'(out1), 32'h1);
        checkOutput("midreset_irq1", 32'(irq1), 32'h0);
        idle(3'd3);
        checkOutput("midreset_cap1", rd1, 32'h0);

        // Unmapped addresses
        busWrite(3'd6, 32'hFFFFFFFF);
        checkOutput("addr6_read", rd0, 32'h0);
        checkOutput("addr6_out0", 32'(out0), 32'h3C);
        idle(3'd7);
        checkOutput("addr7_read", rd0, 32'h0);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            nextIn0 = in0;
            nextIn1 = in1;
            if ($urandom_range(3) == 0) nextIn0 = 8'($urandom);
            if ($urandom_range(3) == 0) nextIn1 = ~in1;
            applyStimulus(($urandom_range(99) == 0), 1'($urandom),
                          1'($urandom), 3'($urandom), $urandom,
                          nextIn0, nextIn1);
        end
        idle(3'd0);

        drained = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (sbq.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0",
                     sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios2_pio_edge_irq.md
Name: nios2_pio_edge_irq

Overview:
- Parametrised Avalon-MM slave PIO; the next generation of the single-bit write-enable output register in the Nios II system.
- Provides a DATA_WIDTH-bit output register with atomic set/clear and a synchronised input port.
- Per-bit edge capture with write-1-to-clear, maskable level interrupt to the Nios II IRQ line.
- Sits on the system interconnect alongside the other PIO slaves; readdata is zero-wait-state (combinational from address).

Parameters:
- DATA_WIDTH, 8, width of out_port/in_port, legal 1..32.
- RESET_VALUE, 0, out_port value after reset, DATA_WIDTH bits.
- EDGE_TYPE, 0, edge detected: 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2, input synchroniser depth, legal 2..3.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word offset of register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data; bits above DATA_WIDTH ignored.
- readdata  out  32  read data; bits above DATA_WIDTH are 0.
- in_port  in  DATA_WIDTH  asynchronous external inputs.
- out_port  out  DATA_WIDTH  registered output.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Clock is clk; reset is synchronous and active-high. On reset:
  - out_port = RESET_VALUE.
  - irq_mask, edge_cap, synchroniser and history flops are all 0.
  - irq = 0.
  - Warm-up counter loaded.
- Register map (word address):
  - 0 OUT: RW; write loads out_reg.
  - 1 IN: RO; synchronised input.
  - 2 IRQ_MASK: RW.
  - 3 EDGE_CAP: read returns captured bits; write-1-to-clear per bit.
  - 4 OUTSET: WO; out_reg |= wd. Reads 0.
  - 5 OUTCLR: WO; out_reg &= ~wd. Reads 0.
  - 6, 7: reads 0; writes ignored.
- Writes take effect at the clk edge where the strobe is sampled; out_port changes on that edge.
- readdata = zero-extended mux of address, combinational, independent of chipselect; 0 wait states, no read side effects.
- Synchroniser: in_port passes SYNC_STAGES flops to in_sync, then 1 history flop in_prev.
- Edge term per bit k:
  - rise = in_sync & ~in_prev.
  - fall = ~in_sync & in_prev.
  - any = rise | fall, selected by EDGE_TYPE.
- Capture latency (SYNC_STAGES=2): in_port change sampled at edge N gives edge_cap[k] = 1 after edge N+2; irq high in the same cycle.
- edge_cap[k] is sticky until cleared by writing 1 to EDGE_CAP bit k.
- Simultaneous clear and new edge on the same bit in the same cycle: set wins, bit stays 1.
- irq = |(edge_cap & irq_mask), combinational from registers, no glitch path from the bus.
- Masking a captured bit drops irq but leaves edge_cap intact; unmasking re-asserts irq.
- Warm-up: captures are suppressed for SYNC_STAGES+1 cycles after reset deasserts, while the synchroniser and history fill. This prevents false edges when in_port is high at reset.
- The warm-up counter is a saturating down-counter of width clog2(SYNC_STAGES+2).
- Reset asserted mid-operation overrides any same-cycle write and clears all state, including pending edges.
- out_port is unaffected by the input path.

Test Plan:
- Reset with in_port=8'hFF, EDGE_TYPE=0, hold 10 cycles -> edge_cap=0, irq=0, IN reads 0x000000FF, out_port=RESET_VALUE.
- Write OUT=0xA5, then OUTSET=0x0F, then OUTCLR=0x81 -> out_port is 0xA5, then 0xAF, then 0x2E, each on the write edge; read OUT returns 0x0000002E; read OUTSET returns 0.
- IRQ_MASK=0x01; pulse in_port[0] 0->1 at edge N -> edge_cap=0x01 and irq=1 after edge N+2.
  - Write EDGE_CAP=0x01 -> edge_cap=0 and irq=0 next cycle.
- EDGE_CAP clear write coincides with a fresh rising edge on bit 3 -> edge_cap[3] remains 1.
- EDGE_TYPE=2, DATA_WIDTH=1, IRQ_MASK=0: toggle in_port 1->0 -> edge_cap=1, irq=0.
  - Then IRQ_MASK=1 -> irq=1. Then assert reset mid-pending -> all 0, out_port=RESET_VALUE.
- Write to address 6 with 0xFFFFFFFF -> no register changes; reads at 6 and 7 return 0; readdata[31:DATA_WIDTH]=0 on all reads.
